// File: rtl/approx_arbiter_pkg.sv
// Shared definitions for the approx core and its arbiter: datapath widths and
// the arbiter state encoding.
package approx_arbiter_pkg;

  localparam int X_W   = 16;
  localparam int Y_W   = 17;
  localparam int NIT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/approx_arbiter_rr.sv
// Combinational round-robin pick: first set request bit searching upward from
// ptr+1 with wrap, returned as a one-hot grant and a binary index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IDX_W = $clog2(N);

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found                        = 1'b1;
        idx                          = IDX_W'((int'(ptr) + i) % N);
        grant[(int'(ptr) + i) % N]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/approx_arbiter.sv
// Shares one approx_top core between N clients: round-robin grant, operand
// latch, start/valid sequencing, result routing and a hung-core watchdog.
module approx_arbiter
  import approx_arbiter_pkg::*;
#(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic [X_W*N-1:0]     x_i,
  input  logic [NIT_W*N-1:0]   nit_i,
  output logic [N-1:0]         ack_o,
  output logic [N-1:0]         done_o,
  output logic [N-1:0]         err_o,
  output logic [Y_W-1:0]       y_o,
  output logic                 busy_o,
  output logic                 core_start_o,
  output logic [X_W-1:0]       core_x_o,
  output logic [NIT_W-1:0]     core_nit_o,
  input  logic                 core_busy_i,
  input  logic                 core_valid_i,
  input  logic [Y_W-1:0]       core_y_i
);

  localparam int IDX_W = $clog2(N);

  state_e             state, state_nx;
  logic [IDX_W-1:0]   ptr, owner, win_idx;
  logic [N-1:0]       win_grant;
  logic               win_found;
  logic               grant_ok;
  logic               timeout_hit;
  logic [CNT_W-1:0]   wd;

  rr_arbiter #(.N(N)) u_rr (
    .req   (req_i),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .found (win_found)
  );

  assign grant_ok    = win_found && !core_busy_i;
  // wd counts completed RUN cycles, so the last allowed RUN cycle sees TIMEOUT_CYC-1.
  assign timeout_hit = (wd == CNT_W'(TIMEOUT_CYC - 1));
  assign busy_o      = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_ok) state_nx = START;
      START:   state_nx = RUN;
      RUN:     if (core_valid_i) state_nx = IDLE;
               else if (timeout_hit) state_nx = DRAIN;
      DRAIN:   if (!core_busy_i && !core_valid_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= IDX_W'(N - 1);
      owner        <= '0;
      wd           <= '0;
      ack_o        <= '0;
      done_o       <= '0;
      err_o        <= '0;
      y_o          <= '0;
      core_start_o <= 1'b0;
      core_x_o     <= '0;
      core_nit_o   <= '0;
    end else begin
      state        <= state_nx;
      ack_o        <= '0;
      done_o       <= '0;
      err_o        <= '0;
      core_start_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_ok) begin
            core_x_o     <= x_i[int'(win_idx)*X_W +: X_W];
            core_nit_o   <= nit_i[int'(win_idx)*NIT_W +: NIT_W];
            owner        <= win_idx;
            ptr          <= win_idx;
            ack_o        <= win_grant;
            core_start_o <= 1'b1;
          end
        end
        START: wd <= '0;
        RUN: begin
          if (core_valid_i) begin
            y_o           <= core_y_i;
            done_o[owner] <= 1'b1;
          end else begin
            wd <= wd + CNT_W'(1);
            if (timeout_hit) err_o[owner] <= 1'b1;
          end
        end
        // Late core results are dropped here; y_o keeps the last good value.
        DRAIN: ;
        default: ;
      endcase
    end
  end

endmodule
